// File: rtl/cpc_int_responder.sv
// cpc_int_responder
//   Interrupt source and acknowledge responder for the CPC gate array, on the Z80 bus side.
//   It counts HSYNC falling edges and raises an interrupt request every INT_LINES lines. The
//   line count is re-aligned a few lines after each VSYNC rise. The responder drives the
//   acknowledge vector during the M1+IORQ cycle and clears the line counter when the
//   gate-array control register is written.
//
// Ports
//   clk       in   system clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   hsync     in   CRTC horizontal sync (clk-synchronous, active high)
//   vsync     in   CRTC vertical sync (clk-synchronous, active high)
//   m1_n      in   Z80 M1 strobe
//   iorq_n    in   Z80 IORQ strobe
//   wr_n      in   Z80 WR strobe
//   A         in   Z80 address bus
//   cpu_dout  in   Z80 write data
//   int_n     out  interrupt request to the CPU, active low
//   ack_dout  out  vector byte for the CPU di mux
//   ack_oe    out  selects ack_dout onto CPU di during interrupt acknowledge
//   line_cnt  out  current line counter
module cpc_int_responder #(
    parameter int unsigned INT_LINES   = 52,
    parameter int unsigned VSYNC_DELAY = 2,
    parameter logic [7:0]  ACK_VECTOR  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        m1_n,
    input  logic        iorq_n,
    input  logic        wr_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic        int_n,
    output logic [7:0]  ack_dout,
    output logic        ack_oe,
    output logic [5:0]  line_cnt
);

    typedef enum logic {StIdle, StPend} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  vsd_q, vsd_d;
    logic        hs_q, vs_q, ack_lvl_q, gawr_lvl_q;

    logic        hs_fall, vs_rise;
    logic        ack_lvl, ack_ev;
    logic        gawr_lvl, gawr_ev, ga_clr;
    logic        set_req, realign;

    // Address/data bits this block does not decode.
    logic        unused_bits;
    assign unused_bits = ^{A[13:0], cpu_dout[5], cpu_dout[3:0]};

    // Each event fires once, when its input first reaches the active state. The previous
    // levels are registered, so a strobe that is held low produces a single event.
    always_comb begin
        hs_fall  = hs_q & ~hsync;
        vs_rise  = ~vs_q & vsync;
        ack_lvl  = ~m1_n & ~iorq_n;
        ack_ev   = ack_lvl & ~ack_lvl_q;
        gawr_lvl = ~iorq_n & ~wr_n & (A[15:14] == 2'b01) & (cpu_dout[7:6] == 2'b10);
        gawr_ev  = gawr_lvl & ~gawr_lvl_q;
        ga_clr   = gawr_ev & cpu_dout[4];
    end

    // Line counter and VSYNC realign.
    always_comb begin
        cnt_d   = cnt_q;
        set_req = 1'b0;
        realign = hs_fall && (vsd_q == 3'd1);

        // An acknowledge clears bit 5, so a realign cannot fire a second interrupt soon after.
        if (ack_ev) begin
            cnt_d[5] = 1'b0;
        end
        if (hs_fall) begin
            cnt_d = cnt_d + 6'd1;
            if (cnt_d == INT_LINES[5:0]) begin
                cnt_d   = 6'd0;
                set_req = 1'b1;
            end
        end
        if (realign) begin
            if (cnt_d[5]) begin
                set_req = 1'b1;
            end
            cnt_d = 6'd0;
        end
        if (ga_clr) begin
            cnt_d   = 6'd0;
            set_req = 1'b0;
        end

        vsd_d = vsd_q;
        if (vs_rise) begin
            vsd_d = VSYNC_DELAY[2:0];
        end else if (hs_fall && (vsd_q != 3'd0)) begin
            vsd_d = vsd_q - 3'd1;
        end
    end

    // Request FSM: a new request beats a simultaneous acknowledge, and a control-register
    // clear beats everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (set_req && !ga_clr) state_d = StPend;
            StPend: if (ga_clr || (ack_ev && !set_req)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 6'd0;
            vsd_q      <= 3'd0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            ack_lvl_q  <= 1'b0;
            gawr_lvl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vsd_q      <= vsd_d;
            hs_q       <= hsync;
            vs_q       <= vsync;
            ack_lvl_q  <= ack_lvl;
            gawr_lvl_q <= gawr_lvl;
        end
    end

    assign int_n    = (state_q != StPend);
    assign ack_oe   = ack_lvl;
    assign ack_dout = ACK_VECTOR;
    assign line_cnt = cnt_q;

endmodule

// File: tb/tb_cpc_int_responder.sv
module tb_cpc_int_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hsync, vsync, m1_n, iorq_n, wr_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        int_n, ack_oe;
    logic [7:0]  ack_dout;
    logic [5:0]  line_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    cpc_int_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hsync    (hsync),
        .vsync    (vsync),
        .m1_n     (m1_n),
        .iorq_n   (iorq_n),
        .wr_n     (wr_n),
        .A        (A),
        .cpu_dout (cpu_dout),
        .int_n    (int_n),
        .ack_dout (ack_dout),
        .ack_oe   (ack_oe),
        .line_cnt (line_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hsync = 0; vsync = 0; m1_n = 1; iorq_n = 1; wr_n = 1; A = 16'h0; cpu_dout = 8'h0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    // One HSYNC pulse; the count updates on the edge that samples hsync low.
    task automatic hs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            hsync = 1; tick();
            hsync = 0; tick();
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        A = addr; cpu_dout = data; iorq_n = 0; wr_n = 0;
        tick();
        iorq_n = 1; wr_n = 1;
        tick();
    endtask

    initial begin
        do_reset();
        check_eq("rst_int_n", int_n, 1);
        check_eq("rst_ack_oe", ack_oe, 0);
        check_eq("rst_ack_dout", ack_dout, 8'hFF);
        check_eq("rst_line_cnt", line_cnt, 0);

        // 51 lines: no interrupt. 52nd line: int_n falls on the next edge.
        hs_pulses(51);
        check_eq("t1_cnt51", line_cnt, 51);
        check_eq("t1_int51", int_n, 1);
        hsync = 1; tick();
        hsync = 0;
        check_eq("t1_int_pre_edge", int_n, 1);
        tick();
        check_eq("t1_int52", int_n, 0);
        check_eq("t1_cnt52", line_cnt, 0);

        // Acknowledge held 4 clocks: ack_oe follows the strobes, the request clears once.
        m1_n = 0; iorq_n = 0; #1;
        check_eq("t2_oe_comb", ack_oe, 1);
        check_eq("t2_dout", ack_dout, 8'hFF);
        check_eq("t2_int_before", int_n, 0);
        tick();
        check_eq("t2_int_cleared", int_n, 1);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_oe_held", ack_oe, 1);
            tick();
        end
        m1_n = 1; iorq_n = 1; #1;
        check_eq("t2_oe_off", ack_oe, 0);
        tick();

        // Ack at line 40 clears bit 5: 40 -> 8, no interrupt.
        do_reset();
        hs_pulses(40);
        m1_n = 0; iorq_n = 0; tick();
        m1_n = 1; iorq_n = 1; tick();
        check_eq("t3_cnt", line_cnt, 8);
        check_eq("t3_int", int_n, 1);

        // VSYNC realign at 35: 35 -> 36 -> 37 and bit 5 set, so an interrupt fires.
        do_reset();
        hs_pulses(35);
        vsync = 1; tick();
        hs_pulses(2);
        check_eq("t4_int35", int_n, 0);
        check_eq("t4_cnt35", line_cnt, 0);
        vsync = 0;
        // Realign at 20 (20 -> 22, bit 5 clear): no interrupt.
        do_reset();
        hs_pulses(20);
        vsync = 1; tick();
        hs_pulses(2);
        check_eq("t4_int20", int_n, 1);
        check_eq("t4_cnt20", line_cnt, 0);
        vsync = 0;

        // Gate-array writes with a request pending and the count at 30.
        do_reset();
        hs_pulses(52 + 30);
        check_eq("t5_setup_cnt", line_cnt, 30);
        check_eq("t5_setup_int", int_n, 0);
        io_write(16'h7F00, 8'h80);
        check_eq("t5_80_cnt", line_cnt, 30);
        check_eq("t5_80_int", int_n, 0);
        io_write(16'hBF00, 8'h90);
        check_eq("t5_badaddr_cnt", line_cnt, 30);
        io_write(16'h7F00, 8'h90);
        check_eq("t5_90_cnt", line_cnt, 0);
        check_eq("t5_90_int", int_n, 1);

        // A new request in the same clock as the acknowledge wins. The count goes 31 -> 32
        // on the realign line (bit 5 set), while the ack clears the earlier request.
        do_reset();
        hs_pulses(52 + 30);
        vsync = 1; tick();
        vsync = 0;
        hs_pulses(1);
        check_eq("t6_cnt31", line_cnt, 31);
        hsync = 1; tick();
        hsync = 0; m1_n = 0; iorq_n = 0; tick();
        check_eq("t6_set_wins", int_n, 0);
        check_eq("t6_cnt", line_cnt, 0);
        m1_n = 1; iorq_n = 1; tick();

        // Asynchronous reset mid-cycle drops the pending request at once.
        hs_pulses(10);
        check_eq("t6_pre_rst_cnt", line_cnt, 10);
        #2 reset_n = 0;
        #1;
        check_eq("t6_rst_cnt", line_cnt, 0);
        check_eq("t6_rst_int", int_n, 1);
        tick();
        reset_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
